mapper_bit_scheduler: RTL and testbench

MAPPER_BIT_SCHEDULER -- requirements
Module: mapper_bit_scheduler

---
 rtl/mapper_pkg.sv | 17 +
 rtl/mapper_bit_counter.sv | 36 +++
 rtl/mapper_bit_scheduler.sv | 142 ++++++++++++++
 tb/tb_mapper_bit_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared types and default widths for the mapper bit scheduler and its bit counter.
// Build option MAPPER_SCHED_STATS_EN adds the stall statistics counter to the scheduler.
package mapper_pkg;

  localparam int unsigned MAPPER_PARALLELISM_DEF = 8;
  localparam int unsigned SYM_CNT_W_DEF          = 16;
  localparam int unsigned CNT_W_DEF              = $clog2(MAPPER_PARALLELISM_DEF);
  localparam int unsigned AVAIL_W_DEF            = CNT_W_DEF + 1;
  localparam int unsigned STALL_CNT_W            = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mapper_bit_counter.sv
// Tracks the valid bits held in the shift-register datapath: +P per FIFO pop, -c per symbol.
// Registered count, one-edge latency; no backpressure of its own (the scheduler keeps it in 0..2P-1).
module mapper_bit_counter
  import mapper_pkg::*;
#(
  parameter  int unsigned MAPPER_PARALLELISM = MAPPER_PARALLELISM_DEF,
  localparam int unsigned BW                 = $clog2(MAPPER_PARALLELISM),
  localparam int unsigned AW                 = BW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fill_i,
  input  logic [BW-1:0] consume_i,
  output logic [AW-1:0] avail_o
);

  localparam logic [AW-1:0] WORD_BITS = AW'(MAPPER_PARALLELISM);

  logic [AW-1:0] avail_q, avail_d;

  // Fill and consume in the same cycle both apply.
  always_comb begin
    avail_d = avail_q + (fill_i ? WORD_BITS : '0) - {1'b0, consume_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      avail_q <= '0;
    end else begin
      avail_q <= avail_d;
    end
  end

  assign avail_o = avail_q;

endmodule

// File: rtl/mapper_bit_scheduler.sv
// Schedules FIFO pops and per-symbol bit consumption for one frame of nsym symbols of bps bits; outputs are combinational from registered state.
// Stalls (sym_valid low) while fewer than bps bits are held and the FIFO is empty; MAPPER_SCHED_STATS_EN adds stall_cnt.
module mapper_bit_scheduler
  import mapper_pkg::*;
#(
  parameter  int unsigned MAPPER_PARALLELISM = MAPPER_PARALLELISM_DEF,
  parameter  int unsigned SYM_CNT_W          = SYM_CNT_W_DEF,
  localparam int unsigned BW                 = $clog2(MAPPER_PARALLELISM),
  localparam int unsigned AW                 = BW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [BW-1:0]        cfg_bps,
  input  logic [SYM_CNT_W-1:0] cfg_nsym,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_req,
  output logic [BW-1:0]        c,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic                 sym_last,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err
`ifdef MAPPER_SCHED_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [AW-1:0] WORD_BITS = AW'(MAPPER_PARALLELISM);

  sched_state_e         state_q, state_d;
  logic [BW-1:0]        bps_q, bps_d;
  logic [SYM_CNT_W-1:0] nsym_q, nsym_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [AW-1:0]        avail;
  logic                 cfg_xfer;
  logic                 cfg_ok;
  logic                 sym_fire;

  mapper_bit_counter #(
    .MAPPER_PARALLELISM(MAPPER_PARALLELISM)
  ) u_cnt (
    .clk_i    (clk),
    .rst_i    (reset),
    .fill_i   (fifo_rd_req),
    .consume_i(c),
    .avail_o  (avail)
  );

  always_comb begin
    cfg_ready   = (state_q == IDLE);
    cfg_xfer    = cfg_valid & cfg_ready;
    cfg_ok      = (cfg_bps != '0) && (cfg_nsym != '0);
    fifo_rd_req = (state_q == RUN) && (avail < WORD_BITS) && !fifo_empty;
    sym_valid   = (state_q == RUN) && (avail >= {1'b0, bps_q});
    sym_fire    = sym_valid & sym_ready;
    sym_last    = sym_valid && (sym_cnt_q == nsym_q - SYM_CNT_W'(1));
    c           = sym_fire ? bps_q : '0;
    busy        = (state_q == RUN) || (state_q == DONE);
    frame_done  = (state_q == DONE);
    cfg_err     = cfg_err_q;
  end

  always_comb begin
    state_d   = state_q;
    bps_d     = bps_q;
    nsym_d    = nsym_q;
    sym_cnt_d = sym_cnt_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_xfer) begin
          if (cfg_ok) begin
            bps_d     = cfg_bps;
            nsym_d    = cfg_nsym;
            sym_cnt_d = '0;
            state_d   = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (sym_fire) begin
          sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
          if (sym_last) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bps_q     <= '0;
      nsym_q    <= '0;
      sym_cnt_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bps_q     <= bps_d;
      nsym_q    <= nsym_d;
      sym_cnt_q <= sym_cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef MAPPER_SCHED_STATS_EN
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Stall: running, not enough bits for a symbol, and nothing to pop.
  always_comb begin
    stall       = (state_q == RUN) && !sym_valid && fifo_empty;
    stall_cnt_d = stall_cnt_q;
    if (cfg_xfer && cfg_ok) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mapper_bit_scheduler.sv
// Scoreboarded bench for mapper_bit_scheduler (P=8): a bit-accounting model predicts each cycle's outputs.
module tb_mapper_bit_scheduler;

  localparam int P  = 8;
  localparam int BW = 3;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [BW-1:0] cfg_bps = '0;
  logic [SW-1:0] cfg_nsym = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_req;
  logic [BW-1:0] c;
  logic          sym_valid;
  logic          sym_ready = 1'b0;
  logic          sym_last;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;
`ifdef MAPPER_SCHED_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  mapper_bit_scheduler #(.MAPPER_PARALLELISM(P), .SYM_CNT_W(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_bps    (cfg_bps),
    .cfg_nsym   (cfg_nsym),
    .fifo_empty (fifo_empty),
    .fifo_rd_req(fifo_rd_req),
    .c          (c),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_last   (sym_last),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
`ifdef MAPPER_SCHED_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  wire [3:0] dut_avail = dut.u_cnt.avail_o;

  typedef struct packed {
    logic        rdy;
    logic        rd;
    logic [2:0]  c;
    logic        sv;
    logic        last;
    logic        busy;
    logic        fd;
    logic        err;
    logic [3:0]  avail;
    logic [15:0] stall;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: phase 0=idle 1=run 2=done; bits held, symbols still owed in the frame.
  int m_phase = 0;
  int m_bits = 0;
  int m_bps = 0;
  int m_left = 0;
  int m_err_pend = 0;
  int m_stall = 0;

  function automatic obs_t sample();
    obs_t a;
    a.rdy   = cfg_ready;
    a.rd    = fifo_rd_req;
    a.c     = c;
    a.sv    = sym_valid;
    a.last  = sym_last;
    a.busy  = busy;
    a.fd    = frame_done;
    a.err   = cfg_err;
    a.avail = dut_avail;
`ifdef MAPPER_SCHED_STATS_EN
    a.stall = stall_cnt;
`else
    a.stall = 16'd0;
`endif
    return a;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_bits = 0; m_bps = 0; m_left = 0; m_err_pend = 0; m_stall = 0;
  endtask

  task automatic cycle(input bit cv, input int bps, input int nsym, input bit fe, input bit sr);
    obs_t e;
    bit   can_sym, fire;
    @(negedge clk);
    cfg_valid  = cv;
    cfg_bps    = bps[2:0];
    cfg_nsym   = nsym[15:0];
    fifo_empty = fe;
    sym_ready  = sr;
    e = '0;
    e.err   = (m_err_pend != 0);
    e.avail = m_bits[3:0];
`ifdef MAPPER_SCHED_STATS_EN
    e.stall = m_stall[15:0];
`endif
    m_err_pend = 0;
    case (m_phase)
      0: begin
        e.rdy = 1'b1;
        if (cv) begin
          if (bps == 0 || nsym == 0) begin
            m_err_pend = 1;
          end else begin
            m_phase = 1; m_bps = bps; m_left = nsym; m_stall = 0;
          end
        end
      end
      1: begin
        e.busy  = 1'b1;
        e.rd    = (m_bits < P) && !fe;
        can_sym = (m_bits >= m_bps);
        fire    = can_sym && sr;
        e.sv    = can_sym;
        e.last  = can_sym && (m_left == 1);
        e.c     = fire ? m_bps[2:0] : 3'd0;
        if (!can_sym && fe && m_stall < 65535) m_stall++;
        m_bits = m_bits + (e.rd ? P : 0) - (fire ? m_bps : 0);
        if (fire) begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
      end
      default: begin
        e.busy  = 1'b1;
        e.fd    = 1'b1;
        m_phase = 0;
      end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit fe, input bit sr);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, fe, sr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cfg_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0b exp=%0b", name, act, exp);
    end
  endtask

  // Monitor: pops one expected record per presented cycle and compares.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outs t=%0t act{rdy,rd,c,sv,last,busy,fd,err,avail,stall}=%b,%b,%0d,%b,%b,%b,%b,%b,%0d,%0d exp=%b,%b,%0d,%b,%b,%b,%b,%b,%0d,%0d",
                   $time, a.rdy, a.rd, a.c, a.sv, a.last, a.busy, a.fd, a.err, a.avail, a.stall,
                   e.rdy, e.rd, e.c, e.sv, e.last, e.busy, e.fd, e.err, e.avail, e.stall);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit cv, fe, sr;
    int bps, nsym;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 0, 0, 1'b1, 1'b0);

    // bps=2 nsym=4, FIFO always ready, consumer always ready.
    cycle(1'b1, 2, 4, 1'b0, 1'b1);
    run(8, 1'b0, 1'b1);

    // bps=3 nsym=3 then a bps=7 single-symbol frame on the residue.
    do_reset();
    cycle(1'b1, 3, 3, 1'b0, 1'b1);
    run(5, 1'b0, 1'b1);
    cycle(1'b1, 7, 1, 1'b0, 1'b1);
    run(4, 1'b0, 1'b1);

    // Starved FIFO from empty datapath, then FIFO recovers.
    do_reset();
    cycle(1'b1, 4, 2, 1'b1, 1'b1);
    run(3, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);

    // Consumer backpressure for 5 cycles.
    cycle(1'b1, 5, 3, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0);
    run(6, 1'b0, 1'b1);

    // Illegal configurations.
    cycle(1'b1, 0, 5, 1'b0, 1'b1);
    run(2, 1'b0, 1'b1);
    cycle(1'b1, 3, 0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 2, 8, 1'b0, 1'b1);
    run(3, 1'b0, 1'b1);
    @(negedge clk);
    #4;
    reset = 1'b1;
    #1;
    check1("async_rst sym_valid", sym_valid, 1'b0);
    check1("async_rst fifo_rd_req", fifo_rd_req, 1'b0);
    check1("async_rst c_zero", (c == '0), 1'b1);
    check1("async_rst busy", busy, 1'b0);
    check1("async_rst cfg_ready", cfg_ready, 1'b1);
    check1("async_rst avail_zero", (dut_avail == 4'd0), 1'b1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Randomized frames, FIFO gaps, consumer stalls and stray cfg_valid.
    for (int i = 0; i < 2500; i++) begin
      cv   = (m_phase == 0) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      bps  = $urandom % 8;
      nsym = ($urandom % 10 == 0) ? 0 : $urandom_range(1, 6);
      fe   = ($urandom % 4 == 0);
      sr   = ($urandom % 4 != 0);
      cycle(cv, bps, nsym, fe, sr);
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain act=%0d pending exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
